// File: rtl/vw_g2u_clk_en_sched.sv
// Multi-channel clock-enable scheduler: per-channel divided enable pulses from
// one base clock, period-aligned start/stop and glitch-free divide updates.
// Ports: i_clk/i_rst (async, active-high), i_ch_run per-channel run level,
//   i_cfg_valid/o_cfg_ready/i_cfg_ch/i_cfg_div config handshake,
//   o_ch_en enable pulses, o_ch_active RUN|DRAIN, o_cfg_err reject pulse,
//   o_busy any channel active or config pending.
module vw_g2u_clk_en_sched #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_ch_run,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [DIV_W-1:0]  i_cfg_div,
  output logic [NUM_CH-1:0] o_ch_en,
  output logic [NUM_CH-1:0] o_ch_active,
  output logic              o_cfg_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic              pend_vld;
  logic              pend_nxt;
  logic [CH_W-1:0]   pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic [NUM_CH-1:0] apply;
  logic              xfer;
  logic              bad;

  assign xfer = i_cfg_valid && o_cfg_ready;
  assign bad  = ({1'b0, i_cfg_ch} >= (CH_W+1)'(NUM_CH))
             || (i_cfg_div == '0);

  // The slot holds at most one request; while it is full o_cfg_ready is low,
  // so acceptance and apply can never fall on the same edge.
  always_comb begin
    pend_nxt = pend_vld;
    if (|apply)
      pend_nxt = 1'b0;
    if (xfer && !bad)
      pend_nxt = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_vld    <= 1'b0;
      pend_ch     <= '0;
      pend_div    <= '0;
      o_cfg_ready <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      pend_vld    <= pend_nxt;
      o_cfg_ready <= !pend_nxt;
      o_cfg_err   <= xfer && bad;
      if (xfer && !bad) begin
        pend_ch  <= i_cfg_ch;
        pend_div <= i_cfg_div;
      end
    end
  end

  assign o_busy = (|o_ch_active) || pend_vld;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           st_q, st_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] eff;
    logic             en_q, en_d;

    // Idle channels take the update at once; running ones only on a reload
    // edge, so the reload itself already uses the new ratio.
    assign apply[c] = pend_vld && (pend_ch == CH_W'(c))
                   && ((st_q == IDLE) || (cnt_q == '0));
    assign eff = apply[c] ? pend_div : div_q;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      en_d  = 1'b0;
      div_d = eff;
      unique case (st_q)
        IDLE: begin
          if (i_ch_run[c]) begin
            st_d  = RUN;
            cnt_d = eff - DIV_W'(1);
          end
        end
        RUN, DRAIN: begin
          if (cnt_q == '0) begin
            en_d  = 1'b1;
            cnt_d = eff - DIV_W'(1);
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
          if (st_q == RUN) begin
            if (!i_ch_run[c])
              st_d = DRAIN;
          end else if (i_ch_run[c]) begin
            st_d = RUN;
          end else if (cnt_q == '0) begin
            st_d = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        st_q  <= IDLE;
        cnt_q <= '0;
        div_q <= DIV_W'(RST_DIV);
        en_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        div_q <= div_d;
        en_q  <= en_d;
      end
    end

    assign o_ch_en[c]     = en_q;
    assign o_ch_active[c] = (st_q != IDLE);
  end

endmodule

// File: tb/tb_vw_g2u_clk_en_sched.sv
// Scoreboard bench for vw_g2u_clk_en_sched: a pulse-time reference model
// predicts every cycle's outputs; a monitor compares after each edge.
module tb_vw_g2u_clk_en_sched;
  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int RD  = 1;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] run = '0;
  logic           cv = 1'b0;
  logic [CW-1:0]  cch = '0;
  logic [DW-1:0]  cdiv = '0;
  logic           rdy_o;
  logic [NCH-1:0] en_o;
  logic [NCH-1:0] act_o;
  logic           err_o;
  logic           busy_o;

  vw_g2u_clk_en_sched #(
    .NUM_CH(NCH), .DIV_W(DW), .RST_DIV(RD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_ch_run(run),
    .i_cfg_valid(cv),
    .o_cfg_ready(rdy_o),
    .i_cfg_ch(cch),
    .i_cfg_div(cdiv),
    .o_ch_en(en_o),
    .o_ch_active(act_o),
    .o_cfg_err(err_o),
    .o_busy(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] en;
    logic [NCH-1:0] act;
    logic           rdy;
    logic           err;
    logic           busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Model: each channel keeps the absolute edge number of its next pulse.
  int t;
  bit m_act[NCH];
  bit m_drn[NCH];
  int m_nxt[NCH];
  int m_div[NCH];
  bit m_pv;
  int m_pch;
  int m_pdiv;
  bit m_rdy;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int c = 0; c < NCH; c++) begin
      m_act[c] = 1'b0;
      m_drn[c] = 1'b0;
      m_nxt[c] = 0;
      m_div[c] = RD;
    end
    m_pv = 1'b0;
    m_pch = 0;
    m_pdiv = 0;
    m_rdy = 1'b0;
  endtask

  task automatic model_edge(output exp_t e);
    bit applied;
    bit acc;
    bit ap;
    int d;
    applied = 1'b0;
    acc = cv && m_rdy;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      ap = m_pv && (m_pch == c) && (!m_act[c] || m_nxt[c] == t);
      d = ap ? m_pdiv : m_div[c];
      if (ap) applied = 1'b1;
      m_div[c] = d;
      if (!m_act[c]) begin
        if (run[c]) begin
          m_act[c] = 1'b1;
          m_drn[c] = 1'b0;
          m_nxt[c] = t + d;
        end
      end else begin
        e.en[c] = (m_nxt[c] == t);
        if (e.en[c]) m_nxt[c] = t + d;
        if (!m_drn[c]) begin
          if (!run[c]) m_drn[c] = 1'b1;
        end else if (run[c]) begin
          m_drn[c] = 1'b0;
        end else if (e.en[c]) begin
          m_act[c] = 1'b0;
        end
      end
      e.act[c] = m_act[c];
    end
    if (applied) m_pv = 1'b0;
    e.err = acc && (int'(cch) >= NCH || cdiv == 0);
    if (acc && !e.err) begin
      m_pv = 1'b1;
      m_pch = int'(cch);
      m_pdiv = int'(cdiv);
    end
    m_rdy = !m_pv;
    e.rdy = m_rdy;
    e.busy = (|e.act) || m_pv;
    t++;
  endtask

  // Called at a falling edge: drive, predict the next edge, advance.
  task automatic step(input logic [NCH-1:0] r, input bit v,
                      input int ch, input int d);
    exp_t e;
    run = r;
    cv = v;
    cch = ch[CW-1:0];
    cdiv = d[DW-1:0];
    model_edge(e);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_steps(input logic [NCH-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0, 0, 0);
  endtask

  // Reset lands mid-cycle, away from any rising edge, so the zero
  // outputs can only come from the asynchronous path.
  task automatic async_reset();
    #2 rst = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("rst_en", 32'(en_o), 0);
    chk("rst_act", 32'(act_o), 0);
    chk("rst_misc", {29'd0, rdy_o, err_o, busy_o}, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("ch_en", 32'(en_o), 32'(e.en));
        chk("ch_active", 32'(act_o), 32'(e.act));
        chk("rdy_err_busy", {29'd0, rdy_o, err_o, busy_o},
            {29'd0, e.rdy, e.err, e.busy});
      end
    end
  end

  initial begin
    logic [NCH-1:0] r;
    model_reset();
    #3;
    chk("init_en", 32'(en_o), 0);
    chk("init_misc", {29'd0, rdy_o, err_o, busy_o}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // ch0 at reset ratio 1: continuous enable
    idle_steps(3'b001, 6);
    idle_steps(3'b000, 3);
    // ch1 to div 4 while idle, then run and stop
    step(3'b000, 1'b1, 1, 4);
    idle_steps(3'b000, 2);
    idle_steps(3'b010, 14);
    idle_steps(3'b000, 8);
    // ch2 at div 3, then retune to 5 mid-period
    step(3'b000, 1'b1, 2, 3);
    idle_steps(3'b100, 5);
    step(3'b100, 1'b1, 2, 5);
    idle_steps(3'b100, 16);
    // rejected requests: zero ratio, out-of-range channel
    step(3'b100, 1'b1, 1, 0);
    step(3'b100, 1'b1, 3, 6);
    step(3'b100, 1'b0, 0, 0);
    idle_steps(3'b000, 8);
    // reset while ch1 drains and a ch2 update is pending
    step(3'b000, 1'b1, 1, 6);
    idle_steps(3'b110, 3);
    step(3'b100, 1'b1, 2, 9);
    idle_steps(3'b100, 1);
    async_reset();
    idle_steps(3'b010, 4);
    idle_steps(3'b000, 2);

    r = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 11) == 0) r[c] = ~r[c];
      step(r, ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      if (i == 1500) async_reset();
    end
    idle_steps('0, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vw_g2u_clk_en_sched.md
Name: vw_g2u_clk_en_sched

Overview:
- Synthesizable, multi-channel clock-enable scheduler for bench and DUT clocking.
- Derives per-channel single-cycle enable pulses from one base clock, with a programmable divide ratio per channel.
- Sequences channel start and stop only on period boundaries, so no channel ever sees a truncated period.
- Accepts divide-ratio reconfiguration through a valid/ready handshake. Updates are applied glitch-free at the next period boundary of the target channel.

Parameters:
- NUM_CH, 4, number of enable channels (1..16).
- DIV_W, 8, width of the divide-ratio field.
- RST_DIV, 1, divide ratio loaded into every channel at reset (1..2^DIV_W-1).

Ports:
- i_clk  input  1  base clock; all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_ch_run  input  NUM_CH  per-channel run request, level-sensitive.
- i_cfg_valid  input  1  config request valid.
- o_cfg_ready  output  1  config slot free.
- i_cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel.
- i_cfg_div  input  DIV_W  new divide ratio D.
- o_ch_en  output  NUM_CH  registered enable pulses.
- o_ch_active  output  NUM_CH  channel in RUN or DRAIN.
- o_cfg_err  output  1  one-cycle pulse: rejected config.
- o_busy  output  1  any channel active or config pending.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - All channels go to IDLE; cnt=0; div=RST_DIV; pending slot cleared.
  - Outputs: o_ch_en=0, o_ch_active=0, o_cfg_err=0, o_busy=0, o_cfg_ready=0 while i_rst=1.
  - o_cfg_ready=1 from the first edge after reset release.
- Per-channel FSM, states IDLE / RUN / DRAIN:
  - IDLE: o_ch_en=0. If i_ch_run=1 at an edge, go to RUN and set cnt<=div-1.
  - RUN: at each edge, if cnt==0 then o_ch_en<=1 and cnt<=div-1; else o_ch_en<=0 and cnt<=cnt-1. If i_ch_run=0, go to DRAIN; counting continues unchanged.
  - DRAIN: counts exactly as in RUN. At the edge where cnt==0, emit the final pulse and go to IDLE. If i_ch_run returns to 1 before then, go back to RUN with phase preserved and no extra or missing pulse.
- Pulse timing:
  - Run sampled at edge k gives the first pulse high in the cycle after edge k+D, then one pulse every D cycles.
  - D=1 gives o_ch_en continuously high while running.
- o_ch_active = state != IDLE.
- Config handshake:
  - Transfer occurs when i_cfg_valid && o_cfg_ready at an edge.
  - Accepted {ch, div} go into a single shared pending slot, and o_cfg_ready<=0.
  - If ch>=NUM_CH or div==0, nothing is stored, o_cfg_err<=1 for one cycle, and o_cfg_ready stays 1.
- Applying a pending update:
  - Target IDLE: applied at the first edge after acceptance.
  - Target RUN/DRAIN: applied at the first reload edge (cnt==0) strictly after acceptance. That reload already uses the new div: cnt<=new_div-1.
  - Apply edge clears the slot; o_cfg_ready<=1 on that same edge.
  - Acceptance on the same edge as a reload does not apply at that reload; it waits for the next one.
- Run start coinciding with apply:
  - If a channel leaves IDLE on the same edge a pending update for it is applied, the start load uses the new div.
- o_busy = |o_ch_active || pending valid.
- Independence: channels are fully independent. Only the config slot is shared.
- Counter width: DIV_W. Counter never underflows because div>=1 is guaranteed by the reset value and by the rejection rule.

Test Plan:
- Reset, then i_ch_run[0]=1 at edge 0 with div=1 -> o_ch_en[0] high continuously from cycle 1; o_cfg_ready=1; all other o_ch_en=0.
- Configure ch1 div=4 while ch1 is IDLE, then run at edge k -> pulses at cycles k+4, k+8, k+12; o_ch_active[1]=1 from k+1.
- ch1 running div=4, drop i_ch_run[1] one cycle after a pulse -> exactly one more pulse 3 cycles later, then IDLE; o_busy falls the cycle after.
- ch2 running div=3, configure div=5 mid-period -> o_cfg_ready low until the next pulse edge; pulse spacing changes 3,3,5,5 with no short period.
- Config with div=0, then config with ch=NUM_CH -> o_cfg_err pulses once per request; o_cfg_ready stays 1; all div registers unchanged.
- Assert i_rst mid-DRAIN while a config is pending -> o_ch_en and o_ch_active drop asynchronously; after release, div=RST_DIV and o_cfg_ready=1.
